// File: rtl/reg_file_2r1w.sv
// Two-read, one-write register file with byte-lane write strobes and registered read ports.
// A read of the address being written in the same cycle returns the merged, write-first value.
module reg_file_2r1w #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 5,
  parameter int ZERO_REG0 = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DATA_W/8-1:0]   wstrb,
  input  logic                  re,
  input  logic [ADDR_W-1:0]     raddr1,
  input  logic [ADDR_W-1:0]     raddr2,
  output logic [DATA_W-1:0]     rdata1,
  output logic [DATA_W-1:0]     rdata2,
  output logic                  rvalid
);

  localparam int unsigned LANES = DATA_W / 8;
  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] merged;
  logic [DATA_W-1:0] next1;
  logic [DATA_W-1:0] next2;
  logic              wr_en;

  // Merged word is both the value stored and the value bypassed to a same-address read.
  always_comb begin
    merged = mem[waddr];
    for (int unsigned i = 0; i < LANES; i++) begin
      if (wstrb[i]) merged[8*i +: 8] = wdata[8*i +: 8];
    end
  end

  always_comb begin
    wr_en = we && !((ZERO_REG0 != 0) && (waddr == '0));
  end

  // The zero-register check comes first so it also masks the bypass path.
  always_comb begin
    next1 = mem[raddr1];
    if ((ZERO_REG0 != 0) && (raddr1 == '0)) next1 = '0;
    else if (we && (raddr1 == waddr))       next1 = merged;
  end

  always_comb begin
    next2 = mem[raddr2];
    if ((ZERO_REG0 != 0) && (raddr2 == '0)) next2 = '0;
    else if (we && (raddr2 == waddr))       next2 = merged;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i[ADDR_W-1:0]] <= '0;
      rdata1 <= '0;
      rdata2 <= '0;
      rvalid <= 1'b0;
    end else begin
      if (wr_en) mem[waddr] <= merged;
      if (re) begin
        rdata1 <= next1;
        rdata2 <= next2;
      end
      rvalid <= re;
    end
  end

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Directed + random bench for reg_file_2r1w; a reference model queues each cycle's expected outputs.
module tb_reg_file_2r1w;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          reset, we, re;
  logic [AW-1:0] waddr, raddr1, raddr2;
  logic [DW-1:0] wdata;
  logic [3:0]    wstrb;
  logic [DW-1:0] rdata1, rdata2;
  logic          rvalid;

  typedef struct {
    logic [DW-1:0] r1;
    logic [DW-1:0] r2;
    logic          v;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] mdl [32];
  logic [DW-1:0] m_r1 = '0;
  logic [DW-1:0] m_r2 = '0;
  int            tests = 0;
  int            fails = 0;

  reg_file_2r1w #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG0(1)) dut (
    .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata), .wstrb(wstrb),
    .re(re), .raddr1(raddr1), .raddr2(raddr2),
    .rdata1(rdata1), .rdata2(rdata2), .rvalid(rvalid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a, input logic w,
                                               input logic [AW-1:0] wa, input logic [DW-1:0] mrg);
    if (a == 0) return '0;
    if (w && a == wa) return mrg;
    return mdl[a];
  endfunction

  // One clock: drive inputs, push the model's expectation, then pop and compare after the edge.
  task automatic cycle(input logic rst, input logic w, input logic [AW-1:0] wa,
                       input logic [DW-1:0] wd, input logic [3:0] ws,
                       input logic r, input logic [AW-1:0] a1, input logic [AW-1:0] a2);
    logic [DW-1:0] mrg;
    exp_t e;
    mrg = mdl[wa];
    for (int i = 0; i < 4; i++) if (ws[i]) mrg[8*i +: 8] = wd[8*i +: 8];
    if (rst) begin
      for (int i = 0; i < 32; i++) mdl[i] = '0;
      m_r1 = '0;
      m_r2 = '0;
      e.v = 1'b0;
    end else begin
      if (r) begin
        m_r1 = model_read(a1, w, wa, mrg);
        m_r2 = model_read(a2, w, wa, mrg);
      end
      if (w && wa != 0) mdl[wa] = mrg;
      e.v = r;
    end
    e.r1 = m_r1;
    e.r2 = m_r2;
    sb.push_back(e);
    reset = rst; we = w; waddr = wa; wdata = wd; wstrb = ws;
    re = r; raddr1 = a1; raddr2 = a2;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      tests++;
      fails++;
      $error("FAIL scoreboard: observed empty queue expected one entry");
    end else begin
      e = sb.pop_front();
      chk("rdata1", rdata1, e.r1);
      chk("rdata2", rdata2, e.r2);
      chk("rvalid", {31'b0, rvalid}, {31'b0, e.v});
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mdl[i] = '0;
    reset = 1'b1; we = 1'b0; re = 1'b0; waddr = '0; wdata = '0; wstrb = '0;
    raddr1 = '0; raddr2 = '0;
    @(negedge clk);

    // Reset with a concurrent write and read: both are lost.
    cycle(1, 1, 5'd4, 32'h12345678, 4'hF, 1, 5'd4, 5'd4);
    chk("rst_rvalid", {31'b0, rvalid}, 32'd0);

    // Post-reset read of arbitrary addresses.
    cycle(0, 0, 0, 0, 0, 1, 5'd3, 5'd31);
    chk("req032_r1", rdata1, 32'h0);
    chk("req032_r2", rdata2, 32'h0);
    chk("req032_v", {31'b0, rvalid}, 32'd1);

    // Partial-strobe overwrite.
    cycle(0, 1, 5'd5, 32'hDEADBEEF, 4'hF, 0, 0, 0);
    cycle(0, 1, 5'd5, 32'h11223344, 4'h3, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 1, 5'd5, 5'd4);
    chk("req033_r1", rdata1, 32'hDEAD3344);

    // Same-edge write and read on both ports.
    cycle(0, 1, 5'd7, 32'hCAFEF00D, 4'hF, 1, 5'd7, 5'd7);
    chk("req034_r1", rdata1, 32'hCAFEF00D);
    chk("req034_r2", rdata2, 32'hCAFEF00D);

    // Entry 0 stays zero, including the bypass path.
    cycle(0, 1, 5'd0, 32'hFFFFFFFF, 4'hF, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 1, 5'd0, 5'd5);
    chk("req035_r1", rdata1, 32'h0);
    cycle(0, 1, 5'd0, 32'hFFFFFFFF, 4'hF, 1, 5'd0, 5'd0);
    chk("req035_byp", rdata1, 32'h0);
    chk("req035_byp2", rdata2, 32'h0);

    // Bypass with partial strobe merges old and new lanes.
    cycle(0, 1, 5'd5, 32'hAABBCCDD, 4'hC, 1, 5'd7, 5'd5);
    chk("merge_byp", rdata2, 32'hAABB3344);

    // Write with empty strobe leaves the entry intact.
    cycle(0, 1, 5'd7, 32'h55555555, 4'h0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 1, 5'd7, 5'd7);
    chk("nostrb", rdata1, 32'hCAFEF00D);

    // Read then hold re low: outputs keep value while writes continue.
    cycle(0, 1, 5'd9, 32'hA5A5A5A5, 4'hF, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 1, 5'd9, 5'd5);
    chk("req036_rd", rdata1, 32'hA5A5A5A5);
    for (int k = 0; k < 3; k++) begin
      cycle(0, 1, 5'd9, 32'h0F0F0F0F, 4'hF, 0, 5'd9, 5'd9);
      chk("req036_hold", rdata1, 32'hA5A5A5A5);
      chk("req036_v", {31'b0, rvalid}, 32'd0);
    end

    // Random concurrent traffic.
    for (int k = 0; k < 60; k++) begin
      cycle(0, 1'($urandom_range(0, 1)), 5'($urandom), $urandom, 4'($urandom),
            1'($urandom_range(0, 1)), 5'($urandom), 5'($urandom));
    end

    // Fill 1..31, reset mid-way through back-to-back reads, then everything reads zero.
    for (int i = 1; i < 32; i++) cycle(0, 1, 5'(i), 32'h01010101 * i + 32'h80000000, 4'hF, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 1, 5'd1, 5'd31);
    chk("fill_r2", rdata2, 32'h9F1F1F1F);
    cycle(0, 0, 0, 0, 0, 1, 5'd2, 5'd30);
    cycle(1, 1, 5'd4, 32'hFFFFFFFF, 4'hF, 1, 5'd4, 5'd31);
    chk("req037_r1", rdata1, 32'h0);
    chk("req037_v", {31'b0, rvalid}, 32'd0);
    for (int i = 0; i < 16; i++) begin
      cycle(0, 0, 0, 0, 0, 1, 5'(i), 5'(31 - i));
      chk("req037_clr1", rdata1, 32'h0);
      chk("req037_clr2", rdata2, 32'h0);
    end

    // First edge after reset accepts a write normally.
    cycle(0, 1, 5'd12, 32'h600DF00D, 4'hF, 1, 5'd12, 5'd3);
    chk("after_rst", rdata1, 32'h600DF00D);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/reg_file_2r1w.md
REG_FILE_2R1W -- requirements
Module: reg_file_2r1w

Interface
REQ-001 Parameter DATA_W, default 32: data width in bits; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_W, default 5: address width; the array SHALL hold 2**ADDR_W entries.
REQ-003 Parameter ZERO_REG0, default 1: when 1, entry 0 SHALL be hardwired to zero.
REQ-004 Clock and reset: one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  clock; all state SHALL update on the rising edge only.
REQ-006 reset  input  1  synchronous active-high reset.
REQ-007 we  input  1  write enable.
REQ-008 waddr  input  ADDR_W  write address.
REQ-009 wdata  input  DATA_W  write data.
REQ-010 wstrb  input  DATA_W/8  byte-lane write mask; bit i SHALL enable wdata[8i+7:8i].
REQ-011 re  input  1  read enable for both read ports.
REQ-012 raddr1  input  ADDR_W  read address, port 1.
REQ-013 raddr2  input  ADDR_W  read address, port 2.
REQ-014 rdata1  output  DATA_W  registered read data, port 1.
REQ-015 rdata2  output  DATA_W  registered read data, port 2.
REQ-016 rvalid  output  1  high for exactly the cycle after each cycle in which re was sampled high.

Function
REQ-017 Write: at an edge with we=1, each byte lane with wstrb bit=1 SHALL be written into entry waddr; lanes with wstrb=0 SHALL keep their old value.
REQ-018 we=1 with wstrb all zero SHALL leave the array unchanged.
REQ-019 With ZERO_REG0=1, writes to waddr=0 SHALL be discarded, and reads of address 0 SHALL return 0 on both ports, including through the bypass.
REQ-020 With ZERO_REG0=0, entry 0 SHALL behave like every other entry.
REQ-021 Read: at an edge with re=1, rdata1 and rdata2 SHALL load the contents of raddr1 and raddr2; latency is 1 cycle.
REQ-022 At an edge with re=0, rdata1 and rdata2 SHALL hold their previous values, and rvalid SHALL go 0.
REQ-023 Bypass: if re=1, we=1 and raddrN==waddr at the same edge, rdataN SHALL take the merged value: new bytes for lanes with wstrb=1, old stored bytes for the other lanes. This is write-first behaviour.
REQ-024 raddr1==raddr2 SHALL give identical rdata1 and rdata2, bypass included.
REQ-025 The two read ports and the write port SHALL operate independently and concurrently every cycle; there is no stall and no back-pressure.
REQ-026 Address inputs SHALL use the full ADDR_W range; no out-of-range case exists.
REQ-027 The block SHALL contain no combinational path from any input to any output.

Reset
REQ-028 At an edge with reset=1:
- every array entry SHALL clear to 0;
- rdata1 and rdata2 SHALL clear to 0;
- rvalid SHALL clear to 0.
REQ-029 Reset SHALL take priority over we and re at the same edge; a write or read presented together with reset SHALL be lost.
REQ-030 Reset asserted mid-operation, for example during back-to-back reads, SHALL take effect at the next edge.
REQ-031 At the first edge after reset deasserts, the block SHALL accept writes and reads normally.

Verification
REQ-032 Reset, then re=1 with raddr1=3 and raddr2=31 -> next cycle rdata1=0, rdata2=0, rvalid=1.
REQ-033 Write waddr=5, wdata=0xDEADBEEF, wstrb=0xF; next cycle write waddr=5, wdata=0x11223344, wstrb=0x3; then read raddr1=5 -> rdata1=0xDEAD3344.
REQ-034 Same edge: we=1, waddr=7, wdata=0xCAFEF00D, wstrb=0xF, re=1, raddr1=7, raddr2=7 (entry 7 previously 0) -> next cycle rdata1=rdata2=0xCAFEF00D.
REQ-035 ZERO_REG0=1: write waddr=0, wdata=0xFFFFFFFF, wstrb=0xF, then read raddr1=0 -> rdata1=0; repeat the write with re=1 at the same edge -> rdata1=0.
REQ-036 Read with re=1 (rdata1=0xA5A5A5A5), then hold re=0 for 3 cycles -> rdata1 stays 0xA5A5A5A5 and rvalid=0 for all 3 cycles.
REQ-037 Fill entries 1-31 with nonzero data, then assert reset together with we=1 and re=1 -> after the edge, all reads return 0, rvalid=0, and the concurrent write is not stored.
